// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read FIFO and sends them as 8N1 UART frames.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic                 i_FifoEmpty,
  output logic                 o_FifoRdEn,
  input  logic [DATA_BITS-1:0] i_FifoRdData,
  output logic                 o_Tx,
  output logic                 o_Busy,
  output logic                 o_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic                 wrap, go;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign wrap = cnt_q == CMAX;
  assign go   = i_Enable && !i_FifoEmpty;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = (state_q inside {IDLE, FETCH, LOAD}) ? '0 : (wrap ? '0 : cnt_q + 1'b1);
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  state_d = go ? FETCH : IDLE;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = i_FifoRdData;
        idx_d   = '0;
        state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^i_FifoRdData;
`endif
      end
      START: state_d = wrap ? DATA : START;
      DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        state_d = (idx_q == IMAX) ? PARITY : DATA;
`else
        state_d = (idx_q == IMAX) ? STOP : DATA;
`endif
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: state_d = wrap ? STOP : PARITY;
`endif
      STOP:    state_d = wrap ? (go ? FETCH : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    tx_d   = (state_d == START) ? 1'b0 :
             (state_d == DATA)  ? shift_d[0] :
`ifdef FIFO_UART_TX_PARITY_EN
             (state_d == PARITY) ? par_d :
`endif
             1'b1;
    rd_d   = state_d == FETCH;
    busy_d = state_d != IDLE;
    done_d = (state_d == STOP) && (cnt_d == CMAX);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_Tx       = tx_q;
  assign o_FifoRdEn = rd_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
endmodule
